// File: rtl/simpu_pkg.sv
// Shared definitions for the simple CPU front end: datapath widths and the
// fetch controller state encoding.
package simpu_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Word-address increment; wraps naturally from 16'hFFFF to 16'h0000.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular instruction queue holding {pc, instruction} pairs between
// fetch and decode. DEPTH must be a power of two so the pointers wrap freely.
module fetch_queue
  import simpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [PC_W-1:0]          push_pc,
  input  logic [INST_W-1:0]        push_inst,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [PC_W-1:0]          head_pc,
  output logic [INST_W-1:0]        head_inst
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= push_pc;
      inst_mem[tail] <= push_inst;
    end
  end

  assign head_pc   = pc_mem[head];
  assign head_inst = inst_mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: registered pc, RUN/HALT controller and push/pop
// arbitration around a small instruction queue feeding decode.
module fetch_unit
  import simpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              halted
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect)  pc <= redirect_pc;
      else if (push) pc <= pc_inc(pc);
    end
  end

  // reset is folded into push so memory is never sampled during initialisation.
  always_comb begin
    state_next = state;
    pop        = out_valid & out_ready & ~redirect;
    push       = (state == RUN) & ~redirect & ~halt_req & ~reset &
                 ((count < DEPTH_C) | pop);
    if (redirect)
      state_next = RUN;
    else if ((state == RUN) && halt_req)
      state_next = HALT;
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_pc   (pc),
    .push_inst (imem_data),
    .pop       (pop),
    .count     (count),
    .head_pc   (out_pc),
    .head_inst (out_inst)
  );

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table covering start-up,
// back-pressure, redirect, halt/drain, pc wrap and reset-in-halt.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [15:0] out_pc;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .halted      (halted)
  );

  // Memory word k holds 32'h1000_0000 + k.
  assign imem_data = 32'h1000_0000 + {16'h0000, imem_addr};

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          redir;
    logic [15:0] rpc;
    bit          halt;
    bit          rdy;
    bit          e_vld;
    logic [15:0] e_pc;
    bit          e_halted;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vec [80];
  int   nvec = 0;

  task automatic add(input bit chk, input bit rst, input bit redir, input logic [15:0] rpc,
                     input bit halt, input bit rdy, input bit e_vld, input logic [15:0] e_pc,
                     input bit e_halted, input logic [15:0] e_addr);
    vec[nvec] = '{chk, rst, redir, rpc, halt, rdy, e_vld, e_pc, e_halted, e_addr};
    nvec++;
  endtask

  task automatic check32(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    // chk rst red rpc     hlt rdy | vld pc      hlt addr
    add(0, 1, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0000);
    // start-up with decode always ready
    add(1, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0000);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 16'h0001);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0001, 0, 16'h0002);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0002, 0, 16'h0003);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0003, 0, 16'h0004);
    // re-reset, then stall decode for 5 cycles after the first valid
    add(1, 1, 0, 16'h0000, 0, 0,   1, 16'h0004, 0, 16'h0005);
    add(1, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, (i == 0) ? 16'h0001 : 16'h0002);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 16'h0002);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0001, 0, 16'h0003);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0002, 0, 16'h0004);
    // redirect to 0x0040 with a full queue and decode ready
    add(1, 0, 1, 16'h0040, 0, 1,   1, 16'h0003, 0, 16'h0005);
    add(1, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0040);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0040, 0, 16'h0041);
    // fill two entries, pulse halt, drain, stay parked
    add(1, 0, 0, 16'h0000, 0, 0,   1, 16'h0041, 0, 16'h0042);
    add(1, 0, 0, 16'h0000, 1, 0,   1, 16'h0041, 0, 16'h0043);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0041, 1, 16'h0043);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0042, 1, 16'h0043);
    for (int i = 0; i < 10; i++)
      add(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0043);
    add(1, 0, 1, 16'h0008, 0, 1,   0, 16'h0000, 1, 16'h0043);
    add(1, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0008);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0008, 0, 16'h0009);
    // pc wrap
    add(1, 0, 1, 16'hFFFE, 0, 1,   1, 16'h0009, 0, 16'h000A);
    add(1, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'hFFFE);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'hFFFE, 0, 16'hFFFF);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'hFFFF, 0, 16'h0000);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 16'h0001);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0001, 0, 16'h0002);
    // full queue in HALT, then one-cycle reset that also sees redirect and halt
    add(1, 0, 0, 16'h0000, 0, 0,   1, 16'h0002, 0, 16'h0003);
    add(1, 0, 0, 16'h0000, 1, 0,   1, 16'h0002, 0, 16'h0004);
    add(1, 1, 1, 16'h1234, 1, 0,   1, 16'h0002, 1, 16'h0004);
    add(1, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0000);
    add(1, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 16'h0001);

    for (int r = 0; r < nvec; r++) begin
      reset       = vec[r].rst;
      redirect    = vec[r].redir;
      redirect_pc = vec[r].rpc;
      halt_req    = vec[r].halt;
      out_ready   = vec[r].rdy;
      if (vec[r].chk) begin
        check32("out_valid", r, {31'd0, out_valid}, {31'd0, vec[r].e_vld});
        check32("halted", r, {31'd0, halted}, {31'd0, vec[r].e_halted});
        check32("imem_addr", r, {16'd0, imem_addr}, {16'd0, vec[r].e_addr});
        if (vec[r].e_vld) begin
          check32("out_pc", r, {16'd0, out_pc}, {16'd0, vec[r].e_pc});
          check32("out_inst", r, out_inst, 32'h1000_0000 + {16'd0, vec[r].e_pc});
        end
      end
      @(posedge clk);
      #1;
    end

    // Held reset: nothing is fetched while reset stays high, even with redirect.
    reset     = 1'b1;
    redirect  = 1'b1;
    redirect_pc = 16'h0077;
    halt_req  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check32("held_reset_addr", 100 + i, {16'd0, imem_addr}, 32'h0);
      check32("held_reset_valid", 100 + i, {31'd0, out_valid}, 32'h0);
    end
    reset    = 1'b0;
    redirect = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!out_valid && waited < 8) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check32("release_latency", 200, waited, 1);
      check32("release_pc", 200, {16'd0, out_pc}, 32'h0);
      check32("release_inst", 200, out_inst, 32'h1000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
